store_fwd_buffer: RTL and testbench

STORE_FWD_BUFFER -- requirements
Module: store_fwd_buffer

---
 rtl/store_fwd_buffer.sv | 121 ++++++++++++
 tb/tb_store_fwd_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_fwd_buffer.sv
// store_fwd_buffer: circular store buffer draining to memory with same-cycle byte-lane load forwarding.
// Define STORE_FWD_PARTIAL_EN to forward partially covered loads instead of stalling them.
module store_fwd_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int NB = DATA_W / 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [NB-1:0]     st_be_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              ld_hit_o,
    output logic [NB-1:0]     ld_be_o,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              ld_stall_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [NB-1:0]     mem_be_o,
    output logic [CW-1:0]     count_o
);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(NB - 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [NB-1:0]     be_q   [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;
    logic [NB-1:0]     cov;
    logic [DATA_W-1:0] mrg;

    assign st_ready_o  = count_q != CW'(DEPTH);
    assign mem_valid_o = count_q != '0;
    assign mem_addr_o  = addr_q[head_q];
    assign mem_data_o  = data_q[head_q];
    assign mem_be_o    = be_q[head_q];
    assign count_o     = count_q;
    assign push        = st_valid_i && st_ready_o;
    assign pop         = mem_valid_o && mem_ready_i;

    always_comb begin
        head_d  = pop ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Walk oldest to youngest so younger stores overwrite older lanes.
    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        cov = '0;
        mrg = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (vld_q[idx] && ((addr_q[idx] ^ ld_addr_i) & WORD_MASK) == '0)
                for (int b = 0; b < NB; b++)
                    if (be_q[idx][b]) begin
                        cov[b]       = 1'b1;
                        mrg[8*b +: 8] = data_q[idx][8*b +: 8];
                    end
        end
    end

    always_comb begin
        ld_hit_o   = 1'b0;
        ld_be_o    = '0;
        ld_data_o  = '0;
        ld_stall_o = 1'b0;
        if (ld_valid_i && cov != '0) begin
            if (&cov) begin
                ld_hit_o  = 1'b1;
                ld_be_o   = '1;
                ld_data_o = mrg;
            end else begin
`ifdef STORE_FWD_PARTIAL_EN
                ld_hit_o  = 1'b1;
                ld_be_o   = cov;
                ld_data_o = mrg;
`else
                ld_stall_o = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (pop) vld_q[head_q] <= 1'b0;
            if (push) begin
                vld_q[tail_q]  <= 1'b1;
                addr_q[tail_q] <= st_addr_i;
                data_q[tail_q] <= st_data_i;
                be_q[tail_q]   <= st_be_i;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_store_fwd_buffer.sv
// tb_store_fwd_buffer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_store_fwd_buffer;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic        clk = 0, rst_n = 0;
    logic        st_valid = 0, st_ready, ld_valid = 0, ld_hit, ld_stall;
    logic        mem_valid, mem_ready = 0;
    logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0, ld_data, mem_addr, mem_data;
    logic [3:0]  st_be = 0, ld_be, mem_be;
    logic [2:0]  count;
    ent_t        q[$];
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    store_fwd_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid_i(st_valid), .st_ready_o(st_ready),
        .st_addr_i(st_addr), .st_data_i(st_data), .st_be_i(st_be),
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr),
        .ld_hit_o(ld_hit), .ld_be_o(ld_be), .ld_data_o(ld_data), .ld_stall_o(ld_stall),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_be_o(mem_be),
        .count_o(count)
    );

    // Expected {stall, hit, be, data}: per lane, the newest queued store to the same word covering it.
    function automatic logic [37:0] model_ld(input logic v, input logic [31:0] a);
        logic [3:0]  cov;
        logic [31:0] d;
        cov = 0;
        d = 0;
        if (!v) return 38'h0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].addr[31:2] == a[31:2])
                for (int b = 0; b < 4; b++)
                    if (q[i].be[b] && !cov[b]) begin
                        cov[b] = 1;
                        d[8*b +: 8] = q[i].data[8*b +: 8];
                    end
        if (cov == 4'h0) return 38'h0;
        if (cov == 4'hF) return {1'b0, 1'b1, 4'hF, d};
`ifdef STORE_FWD_PARTIAL_EN
        return {1'b0, 1'b1, cov, d};
`else
        return {1'b1, 1'b0, 4'h0, 32'h0};
`endif
    endfunction

    task automatic tick();
        bit   pu, po;
        ent_t e;
        pu = st_valid && q.size() != 4;
        po = mem_ready && q.size() != 0;
        e = '{st_addr, st_data, st_be};
        @(posedge clk);
        if (po) void'(q.pop_front());
        if (pu) q.push_back(e);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1; st_addr = a; st_data = d; st_be = be;
        tick();
        st_valid = 0;
    endtask

    task automatic do_reset();
        st_valid = 0; mem_ready = 0; ld_valid = 0;
        @(negedge clk) rst_n = 0;
        q.delete();
        #2 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        ld_valid = 1; ld_addr = 32'h0;
        #1;
        n_tests++;
        if ({st_ready, mem_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL reset_ctrl got rdy=%b mv=%b cnt=%0d exp 1 0 0", st_ready, mem_valid, count);
        end
        n_tests++;
        if ({mem_addr, mem_data, mem_be} !== 68'h0) begin
            n_fail++; $display("FAIL reset_mem got %h %h %h exp 0", mem_addr, mem_data, mem_be);
        end
        n_tests++;
        if ({ld_stall, ld_hit, ld_be, ld_data} !== 38'h0) begin
            n_fail++; $display("FAIL reset_ld got %b %b %h %h exp 0", ld_stall, ld_hit, ld_be, ld_data);
        end
        ld_valid = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        ent_t e;
        for (int i = 0; i < 4; i++) push(32'h40 + 32'(i * 4), $urandom, 4'hF);
        n_tests++;
        if ({count, st_ready} !== {3'd4, 1'b0}) begin
            n_fail++; $display("FAIL fill_full got cnt=%0d rdy=%b exp 4 0", count, st_ready);
        end
        mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            e = q[0];
            n_tests++;
            if ({mem_valid, mem_addr, mem_data, mem_be} !== {1'b1, e}) begin
                n_fail++; $display("FAIL drain_order%0d got %h %h %h exp %h %h %h", i, mem_addr, mem_data, mem_be, e.addr, e.data, e.be);
            end
            tick();
        end
        n_tests++;
        if ({count, mem_valid} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL drain_empty got cnt=%0d mv=%b exp 0 0", count, mem_valid);
        end
        mem_ready = 0;
    endtask

    task automatic test_override();
        do_reset();
        push(32'h100, 32'hAAAAAAAA, 4'hF);
        push(32'h100, 32'hBBBBBBBB, 4'hF);
        ld_valid = 1; ld_addr = 32'h102; #1;
        n_tests++;
        if ({ld_hit, ld_data} !== {1'b1, 32'hBBBBBBBB}) begin
            n_fail++; $display("FAIL override got hit=%b data=%h exp 1 bbbbbbbb", ld_hit, ld_data);
        end
        ld_addr = 32'h104; #1;
        n_tests++;
        if ({ld_stall, ld_hit, ld_be, ld_data} !== 38'h0) begin
            n_fail++; $display("FAIL miss got %b %b %h %h exp 0", ld_stall, ld_hit, ld_be, ld_data);
        end
        ld_valid = 0;
    endtask

    task automatic test_partial();
        do_reset();
        push(32'h200, 32'h11223344, 4'h3);
        ld_valid = 1; ld_addr = 32'h200; #1;
        n_tests++;
`ifdef STORE_FWD_PARTIAL_EN
        if ({ld_stall, ld_hit, ld_be, ld_data} !== {1'b0, 1'b1, 4'h3, 32'h00003344}) begin
            n_fail++; $display("FAIL partial got %b %b %h %h exp 0 1 3 00003344", ld_stall, ld_hit, ld_be, ld_data);
        end
`else
        if ({ld_stall, ld_hit, ld_be, ld_data} !== {1'b1, 1'b0, 4'h0, 32'h0}) begin
            n_fail++; $display("FAIL partial got %b %b %h %h exp 1 0 0 0", ld_stall, ld_hit, ld_be, ld_data);
        end
`endif
        ld_valid = 0;
    endtask

    task automatic test_merge();
        do_reset();
        push(32'h300, 32'hDEAD0000, 4'hC);
        push(32'h300, 32'h0000BEEF, 4'h3);
        ld_valid = 1; ld_addr = 32'h300; #1;
        n_tests++;
        if ({ld_stall, ld_hit, ld_be, ld_data} !== {1'b0, 1'b1, 4'hF, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL merge got %b %b %h %h exp 0 1 f deadbeef", ld_stall, ld_hit, ld_be, ld_data);
        end
        ld_valid = 0;
    endtask

    task automatic test_full_pushpop();
        do_reset();
        push(32'h100, 32'h01020304, 4'hF);
        for (int i = 1; i < 4; i++) push(32'h100 + 32'(i * 4), $urandom, 4'hF);
        st_valid = 1; st_addr = 32'h500; st_data = 32'h55; st_be = 4'hF;
        mem_ready = 1; ld_valid = 1; ld_addr = 32'h100; #1;
        n_tests++;
        if ({st_ready, ld_hit, ld_data} !== {1'b0, 1'b1, 32'h01020304}) begin
            n_fail++; $display("FAIL full_pop_ld got rdy=%b hit=%b data=%h exp 0 1 01020304", st_ready, ld_hit, ld_data);
        end
        tick();
        st_valid = 0; mem_ready = 0; ld_addr = 32'h500; #1;
        n_tests++;
        if ({count, ld_hit, ld_stall} !== {3'd3, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL full_no_push got cnt=%0d hit=%b exp 3 0", count, ld_hit);
        end
        ld_valid = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) push($urandom, $urandom, 4'hF);
        mem_ready = 1;
        @(negedge clk) rst_n = 0;
        q.delete();
        #1;
        n_tests++;
        if ({count, mem_valid, st_ready} !== {3'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL async_reset got cnt=%0d mv=%b rdy=%b exp 0 0 1", count, mem_valid, st_ready);
        end
        #1 rst_n = 1;
        mem_ready = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [37:0] exp_ld;
        ent_t        e;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            st_valid  = ($urandom_range(0, 3) != 0);
            st_addr   = 32'h600 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            st_data   = $urandom;
            st_be     = 4'($urandom);
            mem_ready = ($urandom_range(0, 2) == 0);
            ld_valid  = ($urandom_range(0, 4) != 0);
            ld_addr   = 32'h600 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
            #1;
            exp_ld = model_ld(ld_valid, ld_addr);
            n_tests++;
            if ({count, st_ready, mem_valid} !== {3'(q.size()), q.size() != 4, q.size() != 0}) begin
                n_fail++; $display("FAIL rnd_ctrl c=%0d got cnt=%0d rdy=%b mv=%b exp cnt=%0d", c, count, st_ready, mem_valid, q.size());
            end
            if (q.size() != 0) begin
                e = q[0];
                n_tests++;
                if ({mem_addr, mem_data, mem_be} !== e) begin
                    n_fail++; $display("FAIL rnd_head c=%0d got %h %h %h exp %h %h %h", c, mem_addr, mem_data, mem_be, e.addr, e.data, e.be);
                end
            end
            n_tests++;
            if ({ld_stall, ld_hit, ld_be, ld_data} !== exp_ld) begin
                n_fail++; $display("FAIL rnd_ld c=%0d got %b %b %h %h exp %h", c, ld_stall, ld_hit, ld_be, ld_data, exp_ld);
            end
            tick();
        end
        st_valid = 0; mem_ready = 0; ld_valid = 0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_override();
        test_partial();
        test_merge();
        test_full_pushpop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
